// File: rtl/first_n_cluster_selector_pkg.sv
// Shared defaults and FSM state encoding for the first-N cluster selector.
package first_n_cluster_selector_pkg;

  localparam int MXSBITS_TOTAL_DEF = 1536;
  localparam int MXADRBITS_DEF     = 11;
  localparam int MXCNTBITS_DEF     = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int pass_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/first_n_cluster_selector_cluster_finder.sv
// One encoder partition: holds the working flags and counts, reports the lowest
// set strip each pass and clears it when a search pass is taken.
module cluster_finder
  import first_n_cluster_selector_pkg::*;
#(
  parameter int                   PART_BITS = 768,
  parameter int                   MXADRBITS = MXADRBITS_DEF,
  parameter int                   MXCNTBITS = MXCNTBITS_DEF,
  parameter logic [MXADRBITS-1:0] BASE_ADR  = '0
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           load,
  input  logic                           search_en,
  input  logic [PART_BITS-1:0]           vpfs_in,
  input  logic [PART_BITS*MXCNTBITS-1:0] cnts_in,
  output logic                           found,
  output logic [MXADRBITS-1:0]           adr,
  output logic [MXCNTBITS-1:0]           cnt,
  output logic                           rest_any
);

  logic [PART_BITS-1:0]           vpf_reg;
  logic [PART_BITS*MXCNTBITS-1:0] cnt_reg;
  logic [PART_BITS-1:0]           clr_mask;
  logic [PART_BITS-1:0]           vpf_next;
  logic [MXADRBITS-1:0]           idx;

  // Priority scan from strip 0 upward; the first hit wins.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    cnt      = '0;
    clr_mask = '0;
    for (int i = 0; i < PART_BITS; i++) begin
      if (!found && vpf_reg[i]) begin
        found       = 1'b1;
        idx         = MXADRBITS'(i);
        cnt         = cnt_reg[i*MXCNTBITS +: MXCNTBITS];
        clr_mask[i] = 1'b1;
      end
    end
    vpf_next = vpf_reg & ~clr_mask;
    adr      = found ? idx + BASE_ADR : '0;
    rest_any = |vpf_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vpf_reg <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      vpf_reg <= vpfs_in;
      cnt_reg <= cnts_in;
    end else if (search_en) begin
      vpf_reg <= vpf_next;
    end
  end

endmodule

// File: rtl/first_n_cluster_selector.sv
// Extracts the first CLUSTERS_PER_ENCODER clusters from each partition of the
// s-bit vector over a fixed number of passes and presents all slots together.
module first_n_cluster_selector
  import first_n_cluster_selector_pkg::*;
#(
  parameter int MXSBITS_TOTAL        = MXSBITS_TOTAL_DEF,
  parameter int NUM_ENCODERS         = 2,
  parameter int CLUSTERS_PER_ENCODER = 4,
  parameter int MXADRBITS            = MXADRBITS_DEF,
  parameter int MXCNTBITS            = MXCNTBITS_DEF,
  localparam int NCL = NUM_ENCODERS * CLUSTERS_PER_ENCODER
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               latch_pulse,
  input  logic [MXSBITS_TOTAL-1:0]           vpfs_in,
  input  logic [MXSBITS_TOTAL*MXCNTBITS-1:0] cnts_in,
  output logic [NCL*MXADRBITS-1:0]           adr_out,
  output logic [NCL*MXCNTBITS-1:0]           cnt_out,
  output logic [NCL-1:0]                     vpf_out,
  output logic                               latch_out,
  output logic                               busy,
  output logic                               overflow,
  output logic                               latch_dropped
);

  localparam int PART   = MXSBITS_TOTAL / NUM_ENCODERS;
  localparam int PASS_W = pass_width(CLUSTERS_PER_ENCODER);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(CLUSTERS_PER_ENCODER - 1);

  state_t                   state_reg;
  logic [PASS_W-1:0]        pass_reg;
  logic                     busy_reg;
  logic                     latch_out_reg;
  logic                     latch_dropped_reg;
  logic                     overflow_reg;
  logic [NCL*MXADRBITS-1:0] adr_slot_reg, adr_cur, adr_out_reg;
  logic [NCL*MXCNTBITS-1:0] cnt_slot_reg, cnt_cur, cnt_out_reg;
  logic [NCL-1:0]           vpf_slot_reg, vpf_cur, vpf_out_reg;

  logic                     finder_load;
  logic                     finder_search;
  logic [NUM_ENCODERS-1:0]  f_found;
  logic [NUM_ENCODERS-1:0]  f_rest;
  logic [MXADRBITS-1:0]     f_adr [NUM_ENCODERS];
  logic [MXCNTBITS-1:0]     f_cnt [NUM_ENCODERS];

  assign finder_load   = (state_reg == ST_IDLE) && latch_pulse;
  assign finder_search = (state_reg == ST_SEARCH);

  for (genvar gi = 0; gi < NUM_ENCODERS; gi++) begin : g_enc
    cluster_finder #(
      .PART_BITS (PART),
      .MXADRBITS (MXADRBITS),
      .MXCNTBITS (MXCNTBITS),
      .BASE_ADR  (MXADRBITS'(gi * PART))
    ) u_finder (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (finder_load),
      .search_en (finder_search),
      .vpfs_in   (vpfs_in[gi*PART +: PART]),
      .cnts_in   (cnts_in[gi*PART*MXCNTBITS +: PART*MXCNTBITS]),
      .found     (f_found[gi]),
      .adr       (f_adr[gi]),
      .cnt       (f_cnt[gi]),
      .rest_any  (f_rest[gi])
    );
  end

  // Slot set including this pass, so the final pass can go straight to the outputs.
  always_comb begin
    adr_cur = adr_slot_reg;
    cnt_cur = cnt_slot_reg;
    vpf_cur = vpf_slot_reg;
    for (int e = 0; e < NUM_ENCODERS; e++) begin
      adr_cur[(e*CLUSTERS_PER_ENCODER + int'(pass_reg))*MXADRBITS +: MXADRBITS] = f_adr[e];
      cnt_cur[(e*CLUSTERS_PER_ENCODER + int'(pass_reg))*MXCNTBITS +: MXCNTBITS] = f_cnt[e];
      vpf_cur[e*CLUSTERS_PER_ENCODER + int'(pass_reg)]                         = f_found[e];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= ST_IDLE;
      pass_reg          <= '0;
      busy_reg          <= 1'b0;
      latch_out_reg     <= 1'b0;
      latch_dropped_reg <= 1'b0;
      overflow_reg      <= 1'b0;
      adr_slot_reg      <= '0;
      cnt_slot_reg      <= '0;
      vpf_slot_reg      <= '0;
      adr_out_reg       <= '0;
      cnt_out_reg       <= '0;
      vpf_out_reg       <= '0;
    end else begin
      latch_out_reg     <= 1'b0;
      latch_dropped_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (latch_pulse) begin
            state_reg <= ST_SEARCH;
            pass_reg  <= '0;
            busy_reg  <= 1'b1;
          end
        end
        ST_SEARCH: begin
          latch_dropped_reg <= latch_pulse;
          adr_slot_reg      <= adr_cur;
          cnt_slot_reg      <= cnt_cur;
          vpf_slot_reg      <= vpf_cur;
          if (pass_reg == LAST_PASS) begin
            state_reg     <= ST_DONE;
            pass_reg      <= '0;
            adr_out_reg   <= adr_cur;
            cnt_out_reg   <= cnt_cur;
            vpf_out_reg   <= vpf_cur;
            overflow_reg  <= |f_rest;
            latch_out_reg <= 1'b1;
          end else begin
            pass_reg <= pass_reg + 1'b1;
          end
        end
        ST_DONE: begin
          latch_dropped_reg <= latch_pulse;
          state_reg         <= ST_IDLE;
          busy_reg          <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign adr_out       = adr_out_reg;
  assign cnt_out       = cnt_out_reg;
  assign vpf_out       = vpf_out_reg;
  assign latch_out     = latch_out_reg;
  assign busy          = busy_reg;
  assign overflow      = overflow_reg;
  assign latch_dropped = latch_dropped_reg;

endmodule
